// File: rtl/operand_frame_loader_if.sv
// Byte-stream input and operand-word output handshakes of the operand frame loader.
// The master side feeds bytes and accepts words; the slave side is the loader.
interface operand_frame_loader_if #(
    parameter int IN_W = 8,
    parameter int A_W  = 16,
    parameter int B_W  = 16,
    parameter int C_W  = 11
);
    logic [IN_W-1:0] in_data;
    logic            in_sof;
    logic            in_valid;
    logic            in_ready;
    logic [A_W-1:0]  out_a;
    logic [B_W-1:0]  out_b;
    logic [C_W-1:0]  out_c;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_data, in_sof, in_valid, out_ready,
        input  in_ready, out_a, out_b, out_c, out_valid
    );

    modport slave (
        input  in_data, in_sof, in_valid, out_ready,
        output in_ready, out_a, out_b, out_c, out_valid
    );
endinterface

// File: rtl/operand_frame_loader.sv
// Assembles 6-byte LSB-first frames into a registered {C, B, A} operand word with a
// second holding stage, so one frame can be collected while the previous word stalls.
module operand_frame_loader #(
    parameter int IN_W  = 8,
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int C_W   = 11,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_frame_loader_if.slave bus,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     frame_cnt
);
    localparam int WORD_W = A_W + B_W + C_W;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FULL
    } state_t;

    state_t            state;
    logic [2:0]        idx;
    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] asm_next;
    logic [WORD_W-1:0] out_word_q;
    logic              out_valid_q;
    logic [2:0]        pos;
    logic              slot_free;

    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_word_q[A_W-1:0];
    assign bus.out_b     = out_word_q[A_W+B_W-1:A_W];
    assign bus.out_c     = out_word_q[WORD_W-1:A_W+B_W];

    // A start-of-frame byte always lands in byte 0, whatever the current index.
    assign pos       = bus.in_sof ? 3'd0 : idx;
    assign slot_free = !out_valid_q || bus.out_ready;

    // NOTE: asm_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        asm_next = asm_q;
        case (pos)
            3'd0:    asm_next[0*IN_W +: IN_W] = bus.in_data;
            3'd1:    asm_next[1*IN_W +: IN_W] = bus.in_data;
            3'd2:    asm_next[2*IN_W +: IN_W] = bus.in_data;
            3'd3:    asm_next[3*IN_W +: IN_W] = bus.in_data;
            3'd4:    asm_next[4*IN_W +: IN_W] = bus.in_data;
            default: asm_next[WORD_W-1:5*IN_W] = bus.in_data[WORD_W-5*IN_W-1:0];
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 3'd0;
            asm_q       <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_err <= 1'b0;

            if (out_valid_q && bus.out_ready) begin
                frame_cnt   <= frame_cnt + CNT_W'(1);
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_sof) begin
                            asm_q <= asm_next;
                            idx   <= 3'd1;
                            state <= COLLECT;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (bus.in_valid) begin
                        asm_q <= asm_next;
                        if (bus.in_sof) begin
                            frame_err <= 1'b1;
                            idx       <= 3'd1;
                        end else if (idx == 3'd5) begin
                            idx <= 3'd0;
                            // Last byte goes straight to the output when the slot frees this cycle.
                            if (slot_free) begin
                                out_word_q  <= asm_next;
                                out_valid_q <= 1'b1;
                                state       <= IDLE;
                            end else begin
                                state <= FULL;
                            end
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end

                FULL: begin
                    if (slot_free) begin
                        out_word_q  <= asm_q;
                        out_valid_q <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_frame_loader.sv
// Bench for operand_frame_loader: directed scenarios plus random traffic against a
// frame-level model (a two-deep queue of finished words and a list of pending bytes).
module tb_operand_frame_loader;
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [10:0] c;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic        frame_err4;
    logic [3:0]  frame_cnt4;

    always #5 clk = ~clk;

    operand_frame_loader_if bus ();
    operand_frame_loader_if bus4 ();

    operand_frame_loader dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, so counter wrap is reachable quickly.
    operand_frame_loader #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus4),
        .frame_err (frame_err4),
        .frame_cnt (frame_cnt4)
    );

    assign bus4.in_data   = bus.in_data;
    assign bus4.in_sof    = bus.in_sof;
    assign bus4.in_valid  = bus.in_valid;
    assign bus4.out_ready = bus.out_ready;

    word_t       q[$];
    logic [7:0]  cur[$];
    word_t       last_word = '0;
    int unsigned cnt = 0;
    logic        exp_err = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic model_update(input logic v, input logic sof, input logic [7:0] d,
                                input logic rdy, input logic r);
        logic  acc;
        word_t w;
        if (r) begin
            q.delete();
            cur.delete();
            last_word = '0;
            cnt       = 0;
            exp_err   = 1'b0;
            return;
        end
        exp_err = 1'b0;
        acc = v && (q.size() < 2);
        if (rdy && q.size() > 0) begin
            last_word = q.pop_front();
            cnt++;
        end
        if (acc) begin
            if (sof) begin
                if (cur.size() > 0) exp_err = 1'b1;
                cur.delete();
                cur.push_back(d);
            end else if (cur.size() == 0) begin
                exp_err = 1'b1;
            end else begin
                cur.push_back(d);
                if (cur.size() == 6) begin
                    w.a = {cur[1], cur[0]};
                    w.b = {cur[3], cur[2]};
                    w.c = {cur[5][2:0], cur[4]};
                    q.push_back(w);
                    cur.delete();
                end
            end
        end
    endtask

    function automatic logic [66:0] exp_vec();
        word_t       w;
        int unsigned c4;
        w  = last_word;
        if (q.size() > 0) w = q[0];
        c4 = cnt % 16;
        return {q.size() < 2, q.size() > 0, w, exp_err, cnt[15:0], exp_err, c4[3:0]};
    endfunction

    function automatic logic [66:0] obs_vec();
        return {bus.in_ready, bus.out_valid, bus.out_a, bus.out_b, bus.out_c,
                frame_err, frame_cnt, frame_err4, frame_cnt4};
    endfunction

    task automatic step(input logic v, input logic sof, input logic [7:0] d,
                        input logic rdy, input logic r = 1'b0);
        bus.in_valid  = v;
        bus.in_sof    = sof;
        bus.in_data   = d;
        bus.out_ready = rdy;
        rst           = r;
        @(posedge clk);
        model_update(v, sof, d, rdy, r);
        #1;
    endtask

    task automatic send_frame(input logic [47:0] f, input logic rdy);
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, f[8*i +: 8], rdy);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_state got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
        if ({bus.in_ready, bus.out_valid, frame_cnt, bus.out_a} !== {1'b1, 1'b0, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset_values got rdy=%b v=%b cnt=%h a=%h want 1 0 0000 0000",
                     bus.in_ready, bus.out_valid, frame_cnt, bus.out_a);
        end
        checks++;
    endtask

    task automatic test_single_frame();
        send_frame(48'h07FF_5678_1234, 1'b1);
        if ({bus.out_valid, bus.out_a, bus.out_b, bus.out_c} !== {1'b1, 16'h1234, 16'h5678, 11'h7FF}) begin
            errors++;
            $display("FAIL single_word got v=%b a=%h b=%h c=%h want 1 1234 5678 7ff",
                     bus.out_valid, bus.out_a, bus.out_b, bus.out_c);
        end
        checks++;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        if ({bus.out_valid, frame_cnt} !== {1'b0, 16'd1}) begin
            errors++; $display("FAIL single_after got v=%b cnt=%0d want 0 1", bus.out_valid, frame_cnt);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL single_model got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_c_mask();
        send_frame(48'hFDAB_0002_0001, 1'b1);
        if ({bus.out_valid, bus.out_c, bus.out_a} !== {1'b1, 11'h5AB, 16'h0001}) begin
            errors++;
            $display("FAIL c_mask got v=%b c=%h a=%h want 1 5ab 0001", bus.out_valid, bus.out_c, bus.out_a);
        end
        checks++;
        step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [47:0] f2;
        f2 = {$urandom, $urandom};
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        send_frame(48'h05AA_BBBB_CCCC, 1'b0);
        send_frame(f2, 1'b0);
        if ({bus.in_ready, bus.out_valid, bus.out_a} !== {1'b0, 1'b1, 16'hCCCC}) begin
            errors++;
            $display("FAIL bp_full got rdy=%b v=%b a=%h want 0 1 cccc", bus.in_ready, bus.out_valid, bus.out_a);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'h99, 1'b0);
            if ({bus.in_ready, bus.out_valid, bus.out_a, bus.out_b, bus.out_c} !==
                {1'b0, 1'b1, 16'hCCCC, 16'hBBBB, 11'h5AA}) begin
                errors++;
                $display("FAIL bp_hold got rdy=%b v=%b a=%h b=%h c=%h want 0 1 cccc bbbb 5aa",
                         bus.in_ready, bus.out_valid, bus.out_a, bus.out_b, bus.out_c);
            end
            checks++;
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        if ({bus.in_ready, bus.out_valid, bus.out_a, bus.out_b, bus.out_c, frame_cnt} !==
            {1'b1, 1'b1, f2[15:0], f2[31:16], f2[42:32], 16'd1}) begin
            errors++;
            $display("FAIL bp_second got rdy=%b v=%b a=%h b=%h c=%h cnt=%0d want 1 1 %h %h %h 1",
                     bus.in_ready, bus.out_valid, bus.out_a, bus.out_b, bus.out_c, frame_cnt,
                     f2[15:0], f2[31:16], f2[42:32]);
        end
        checks++;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        if ({bus.out_valid, frame_cnt} !== {1'b0, 16'd2}) begin
            errors++; $display("FAIL bp_done got v=%b cnt=%0d want 0 2", bus.out_valid, frame_cnt);
        end
        checks++;
    endtask

    task automatic test_resync();
        step(1'b1, 1'b1, 8'hAA, 1'b1);
        step(1'b1, 1'b0, 8'hBB, 1'b1);
        step(1'b1, 1'b0, 8'hCC, 1'b1);
        step(1'b1, 1'b1, 8'h01, 1'b1);
        if (frame_err !== 1'b1) begin
            errors++; $display("FAIL resync_err got %b want 1", frame_err);
        end
        checks++;
        step(1'b1, 1'b0, 8'h00, 1'b1);
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL resync_pulse got %b want 0", frame_err);
        end
        checks++;
        step(1'b1, 1'b0, 8'h02, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h03, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        if ({bus.out_valid, bus.out_a, bus.out_b, bus.out_c} !== {1'b1, 16'h0001, 16'h0002, 11'h003}) begin
            errors++;
            $display("FAIL resync_word got v=%b a=%h b=%h c=%h want 1 0001 0002 003",
                     bus.out_valid, bus.out_a, bus.out_b, bus.out_c);
        end
        checks++;
        step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_stray_byte();
        step(1'b1, 1'b0, 8'h55, 1'b1);
        if ({frame_err, bus.out_valid} !== 2'b10) begin
            errors++; $display("FAIL stray_err got err=%b v=%b want 1 0", frame_err, bus.out_valid);
        end
        checks++;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        if ({frame_err, bus.out_valid} !== 2'b00) begin
            errors++; $display("FAIL stray_quiet got err=%b v=%b want 0 0", frame_err, bus.out_valid);
        end
        checks++;
        send_frame(48'h0123_4567_89AB, 1'b1);
        if ({bus.out_valid, bus.out_a, bus.out_b, bus.out_c} !== {1'b1, 16'h89AB, 16'h4567, 11'h123}) begin
            errors++;
            $display("FAIL stray_next got v=%b a=%h b=%h c=%h want 1 89ab 4567 123",
                     bus.out_valid, bus.out_a, bus.out_b, bus.out_c);
        end
        checks++;
        step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_midframe();
        send_frame(48'h0444_3333_2222, 1'b0);
        step(1'b1, 1'b1, 8'h10, 1'b0);
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h12, 1'b0);
        step(1'b1, 1'b0, 8'h13, 1'b0);
        step(1'b1, 1'b0, 8'h14, 1'b0, 1'b1);
        if ({bus.out_valid, frame_cnt, bus.in_ready, frame_err, bus.out_a, bus.out_c} !==
            {1'b0, 16'd0, 1'b1, 1'b0, 16'h0, 11'h0}) begin
            errors++;
            $display("FAIL rst_mid got v=%b cnt=%0d rdy=%b err=%b a=%h c=%h want 0 0 1 0 0000 000",
                     bus.out_valid, frame_cnt, bus.in_ready, frame_err, bus.out_a, bus.out_c);
        end
        checks++;
        send_frame(48'h0007_0006_0005, 1'b1);
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rst_after got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
        step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_back_to_back_wrap();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 6; i++) begin
                step(1'b1, i == 0, 8'($urandom), 1'b1);
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL b2b_model got %h want %h", obs_vec(), exp_vec());
                end
                checks++;
            end
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        if ({frame_cnt, frame_cnt4} !== {16'd16, 4'd0}) begin
            errors++; $display("FAIL cnt_wrap got %0d/%0d want 16/0", frame_cnt, frame_cnt4);
        end
        checks++;
    endtask

    task automatic test_random();
        logic v, sof, rdy, r;
        for (int n = 0; n < 3000; n++) begin
            v   = $urandom_range(0, 3) != 0;
            sof = (cur.size() == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 29) == 0);
            rdy = $urandom_range(0, 9) < 7;
            r   = $urandom_range(0, 499) == 0;
            step(v, sof, 8'($urandom), rdy, r);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_cycle%0d got %h want %h", n, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_c_mask();
        test_backpressure();
        test_resync();
        test_stray_byte();
        test_reset_midframe();
        test_back_to_back_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
